// File: rtl/ysyx_23060201_ifu_fetch_pkg.sv
// Shared constants and FSM state codes for the IFU fetch stage.
// The NOP encoding exists only when YSYX_23060201_IFU_ALIGN_CHECK_EN is defined.
package ysyx_23060201_ifu_fetch_pkg;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

`ifdef YSYX_23060201_IFU_ALIGN_CHECK_EN
   localparam logic [31:0] IFU_NOP = 32'h0000_0013;
`endif

   typedef enum logic [1:0] {
      IFU_S_REQ  = 2'b00,
      IFU_S_WAIT = 2'b01,
      IFU_S_HOLD = 2'b10
   } ifu_state_e;

endpackage

// File: rtl/ysyx_23060201_ifu_fetch_reg.sv
// Generic register with an asynchronous, active-high reset to a parameterised value.
module ysyx_23060201_Reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Storage flop; callers hold their value by feeding q back through d.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/ysyx_23060201_ifu_fetch.sv
// IFU fetch stage: one imem request per instruction, presents {pc, inst} downstream.
// Optional macro YSYX_23060201_IFU_ALIGN_CHECK_EN turns a misaligned PC into a faulting NOP.
module ysyx_23060201_ifu_fetch
   import ysyx_23060201_ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic            clk_a,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            imem_resp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst,
   output logic            out_err,
   input  logic [XLEN-1:0] dnpc,
   output logic [31:0]     fetch_cnt
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            err_q, err_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            req_valid_s;
   logic            out_valid_s;

   // FSM state register.
   always_ff @(posedge clk_a or posedge rst) begin
      if (rst) begin
         state_q <= IFU_S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, datapath updates and state-decoded handshake outputs.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      req_valid_s = 1'b0;
      out_valid_s = 1'b0;
      case (state_q)
         IFU_S_REQ: begin
`ifdef YSYX_23060201_IFU_ALIGN_CHECK_EN
            // A misaligned PC never reaches memory; it is handed off as a faulting NOP.
            if (pc_q[1:0] != 2'b00) begin
               inst_d  = XLEN'(IFU_NOP);
               err_d   = 1'b1;
               state_d = IFU_S_HOLD;
            end else begin
               req_valid_s = 1'b1;
               if (imem_req_ready) begin
                  state_d = IFU_S_WAIT;
               end else begin
                  state_d = IFU_S_REQ;
               end
            end
`else
            req_valid_s = 1'b1;
            if (imem_req_ready) begin
               state_d = IFU_S_WAIT;
            end else begin
               state_d = IFU_S_REQ;
            end
`endif
         end
         IFU_S_WAIT: begin
            if (imem_resp_valid) begin
               inst_d  = imem_resp_data;
               err_d   = imem_resp_err;
               state_d = IFU_S_HOLD;
            end else begin
               state_d = IFU_S_WAIT;
            end
         end
         IFU_S_HOLD: begin
            out_valid_s = 1'b1;
            if (out_ready) begin
               pc_d    = dnpc;
               cnt_d   = cnt_q + 32'd1;
               state_d = IFU_S_REQ;
            end else begin
               state_d = IFU_S_HOLD;
            end
         end
         default: begin
            state_d = IFU_S_REQ;
         end
      endcase
   end

   ysyx_23060201_Reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
      .clk (clk_a),
      .rst (rst),
      .d   (pc_d),
      .q   (pc_q)
   );

   ysyx_23060201_Reg #(.WIDTH(XLEN), .RESET_VAL({XLEN{1'b0}})) u_inst (
      .clk (clk_a),
      .rst (rst),
      .d   (inst_d),
      .q   (inst_q)
   );

   ysyx_23060201_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_err (
      .clk (clk_a),
      .rst (rst),
      .d   (err_d),
      .q   (err_q)
   );

   ysyx_23060201_Reg #(.WIDTH(32), .RESET_VAL(32'd0)) u_cnt (
      .clk (clk_a),
      .rst (rst),
      .d   (cnt_d),
      .q   (cnt_q)
   );

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = pc_q;
   assign out_valid      = out_valid_s;
   assign out_pc         = pc_q;
   assign out_inst       = inst_q;
   assign out_err        = err_q;
   assign fetch_cnt      = cnt_q;

endmodule

// File: doc/ysyx_23060201_ifu_fetch.md
Name: ysyx_23060201_ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the EXU.
- Holds the architectural PC and issues one request per instruction to the instruction memory over a valid/ready port.
- Captures the returned instruction and presents {pc, inst} to the decode/execute path with a valid/ready handshake.
- Loads the EXU-computed dnpc as the next PC when the current instruction is accepted.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk_a  in  1  stage clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, equal to the current PC.
- imem_resp_valid  in  1  read data valid.
- imem_resp_data  in  XLEN  instruction word.
- imem_resp_err  in  1  bus error on this fetch.
- out_valid  out  1  {out_pc, out_inst} valid to downstream.
- out_ready  in  1  downstream (IDU/EXU) accepts.
- out_pc  out  XLEN  PC of the presented instruction.
- out_inst  out  XLEN  presented instruction.
- out_err  out  1  fetch fault attached to the presented instruction.
- dnpc  in  XLEN  next PC from EXU, sampled only on out handshake.
- fetch_cnt  out  32  count of accepted instructions.

Behaviour:
- Reset (async, rst=1): state=S_REQ, pc=RESET_PC, out_inst=0, out_err=0, fetch_cnt=0. All outputs are registered or decoded from state, so out_valid=0, imem_req_valid=1 from the first cycle after release, and imem_req_addr=RESET_PC.
- FSM states: S_REQ, S_WAIT, S_HOLD (2-bit encoding; unused code returns to S_REQ).
- S_REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_valid&imem_req_ready, go to S_WAIT. Addr and valid stay stable until accepted.
- S_WAIT: imem_req_valid=0. On imem_resp_valid, out_inst<=imem_resp_data and out_err<=imem_resp_err, then go to S_HOLD. imem_resp_valid is ignored in S_REQ and S_HOLD.
- S_HOLD: out_valid=1 and out_pc=pc. out_inst, out_pc and out_err stay stable while out_ready=0. On out_ready, pc<=dnpc, fetch_cnt<=fetch_cnt+1 (wraps 2^32-1 -> 0), then go to S_REQ.
- Latency: at least 3 cycles per instruction (req accept, response, hand-off). A response in the cycle right after acceptance is the minimum; the memory must not return a response in the same cycle as acceptance.
- A memory error does not stall the stage: the word is forwarded with out_err=1 and the PC still advances to dnpc.
- dnpc is combinational from EXU and is valid only while out_valid=1. It is sampled only on the out handshake.
- Reset mid-transaction (S_WAIT or S_HOLD): the state drops to S_REQ immediately and any late response is ignored, because it arrives outside S_WAIT.
- At most one outstanding request; no speculation and no buffering beyond one instruction.

Optional Feature:
- Macro: YSYX_23060201_IFU_ALIGN_CHECK_EN.
- Defined: in S_REQ, if pc[1:0]!=0, no imem request is issued. The stage goes directly to S_HOLD with out_inst=32'h0000_0013 (nop), out_err=1 and out_pc=pc. The handshake then proceeds as normal.
- Undefined: pc[1:0] is sent to memory unchanged; no check logic is present.

Decomposition:
- Shared defines (defines.v): RESET_PC default, FSM state codes (IFU_S_REQ/IFU_S_WAIT/IFU_S_HOLD) and the NOP encoding.
- One sub-module: ysyx_23060201_Reg, a generic reset-value register used for pc, out_inst, out_err and fetch_cnt. The FSM stays inline.

Test Plan:
- Reset release, imem_req_ready=1, response 1 cycle later with data 32'h0010_0093, out_ready=1, dnpc=32'h8000_0004:
  - imem_req_addr=32'h8000_0000.
  - out_valid rises 2 cycles after request accept with out_pc=32'h8000_0000 and out_inst=32'h0010_0093.
  - The next request has addr 32'h8000_0004; fetch_cnt=1.
- Backpressure: out_ready=0 for 5 cycles in S_HOLD -> out_* stable and no new request; on out_ready=1, exactly one pc update.
- Memory stall: imem_req_ready=0 for 4 cycles, then resp delayed 3 cycles -> addr held constant, no out_valid until data arrives.
- Jump: dnpc=32'h8000_0100 at hand-off -> next imem_req_addr=32'h8000_0100.
- Error: imem_resp_err=1 -> out_err=1 with data forwarded and PC still advancing. With the macro defined, dnpc=32'h8000_0102 -> no request issued, out_inst=32'h0000_0013 and out_err=1.
- Async rst asserted in S_WAIT, then a late response arrives -> response is ignored, state is S_REQ, pc=RESET_PC, fetch_cnt=0; fetch_cnt wrap from 32'hFFFF_FFFF -> 0.
